// File: rtl/hit_stream_tx_pkg.sv
// Shared definitions for the hit-word bus: layer codes, word widths, hit field layout
// and word formatting helpers used by the transmitter and the receiver bench.
package hit_stream_tx_pkg;

    localparam int unsigned WORD_W        = 23;
    localparam int unsigned HIT_W         = 19;
    localparam int unsigned LAYER_W       = 3;
    localparam int unsigned CNT_W         = 10;
    localparam int unsigned SVX_PAYLOAD_W = 18;

    // SVX hit field layout: {2'b0, z, sign, coord}
    localparam int unsigned COORD_W   = 14;
    localparam int unsigned COORD_LSB = 0;
    localparam int unsigned SIGN_LSB  = 14;
    localparam int unsigned Z_W       = 3;
    localparam int unsigned Z_LSB     = 15;

    // XFT hit field layout: {c_sign, c_mag, phi}
    localparam int unsigned PHI_W      = 12;
    localparam int unsigned PHI_LSB    = 0;
    localparam int unsigned C_MAG_W    = 6;
    localparam int unsigned C_MAG_LSB  = 12;
    localparam int unsigned C_SIGN_LSB = 18;

    localparam logic [LAYER_W-1:0] LAYER_XFT     = 3'd5;
    localparam logic [LAYER_W-1:0] LAYER_TRAILER = 3'd7;

    localparam logic [WORD_W-1:0] XFT_MARKER = {2'b00, LAYER_XFT, 18'b0};

    typedef struct packed {
        logic [1:0]         pad;
        logic [Z_W-1:0]     z;
        logic               sign;
        logic [COORD_W-1:0] coord;
    } svx_hit_t;

    typedef struct packed {
        logic               c_sign;
        logic [C_MAG_W-1:0] c_mag;
        logic [PHI_W-1:0]   phi;
    } xft_hit_t;

    typedef enum logic [2:0] {
        S_IDLE,
        S_CLR,
        S_SVX,
        S_XHDR,
        S_XDAT,
        S_DONE
    } tx_state_t;

    function automatic logic is_svx_layer(input logic [LAYER_W-1:0] layer);
        return layer <= 3'd4;
    endfunction

    function automatic logic [WORD_W-1:0] svx_word(input logic [LAYER_W-1:0]       layer,
                                                   input logic [SVX_PAYLOAD_W-1:0] payload);
        return {2'b00, layer, payload};
    endfunction

    function automatic logic [WORD_W-1:0] xft_word(input xft_hit_t hit);
        return {4'b0000, hit};
    endfunction

endpackage

// File: rtl/hit_stream_tx_xft_fifo.sv
// Show-ahead synchronous FIFO holding the XFT hits of the current event until the
// SVX words are out; pointer reset doubles as the mid-event flush.
module hit_stream_tx_xft_fifo
    import hit_stream_tx_pkg::*;
#(
    parameter int unsigned DEPTH = 16,
    parameter int unsigned WIDTH = HIT_W
) (
    input  logic                     clock,
    input  logic                     reset_n,
    input  logic                     push,
    input  logic                     pop,
    input  logic [WIDTH-1:0]         wr_data,
    output logic [WIDTH-1:0]         rd_data,
    output logic                     full,
    output logic                     empty,
    output logic [$clog2(DEPTH):0]   count
);

    localparam int unsigned AW = $clog2(DEPTH);
    localparam int unsigned CW = AW + 1;

    logic [WIDTH-1:0] mem [DEPTH];
    logic [AW-1:0]    wr_ptr;
    logic [AW-1:0]    rd_ptr;
    logic [CW-1:0]    level;
    logic             do_push;
    logic             do_pop;

    assign do_push = push && !full;
    assign do_pop  = pop && !empty;

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
        end else begin
            if (do_push) wr_ptr <= wr_ptr + AW'(1);
            if (do_pop)  rd_ptr <= rd_ptr + AW'(1);
            level <= level + CW'(do_push) - CW'(do_pop);
        end
    end

    // Storage needs no reset: the pointers define what is valid.
    always_ff @(posedge clock) begin
        if (do_push) mem[wr_ptr] <= wr_data;
    end

    assign rd_data = mem[rd_ptr];
    assign full    = (level == CW'(DEPTH));
    assign empty   = (level == '0);
    assign count   = level;

endmodule

// File: rtl/hit_stream_tx.sv
// Hit-word bus transmitter: clear pulse, SVX words in arrival order, then buffered
// XFT hits as marker/data pairs, with per-event word count and error pulses.
module hit_stream_tx
    import hit_stream_tx_pkg::*;
#(
    parameter int unsigned XFT_DEPTH = 16
) (
    input  logic               clock,
    input  logic               reset_n,
    input  logic               hit_valid,
    output logic               hit_ready,
    input  logic [LAYER_W-1:0] hit_layer,
    input  logic [HIT_W-1:0]   hit_data,
    input  logic               hit_eoe,
    input  logic               tx_hold,
    output logic [WORD_W-1:0]  dout,
    output logic               we,
    output logic               clear,
    output logic               evt_done,
    output logic [CNT_W-1:0]   evt_words,
    output logic               err_layer,
    output logic               err_xft_ovf
);

    localparam int unsigned FIFO_CW = $clog2(XFT_DEPTH) + 1;
    localparam logic [CNT_W-1:0] CNT_MAX = '1;

    tx_state_t          state;
    logic               accept;
    logic               is_svx;
    logic               is_xft;
    logic               bad_layer;
    logic               push;
    logic               pop;
    logic               emit;
    logic               fifo_full;
    logic               fifo_empty;
    logic [HIT_W-1:0]   fifo_rd_data;
    logic [FIFO_CW-1:0] fifo_level;
    logic [CNT_W-1:0]   word_cnt;
    logic [CNT_W-1:0]   cnt_next;

    // Ready depends only on state and hold, never on the hit itself.
    assign hit_ready = (state == S_SVX) && !tx_hold;
    assign accept    = hit_valid && hit_ready;
    assign is_svx    = is_svx_layer(hit_layer);
    assign is_xft    = (hit_layer == LAYER_XFT);
    assign bad_layer = !is_svx && !is_xft && !((hit_layer == LAYER_TRAILER) && hit_eoe);
    assign push      = accept && is_xft && !fifo_full;
    assign pop       = (state == S_XDAT) && !tx_hold;
    assign emit      = (accept && is_svx)
                     || (((state == S_XHDR) || (state == S_XDAT)) && !tx_hold);
    assign cnt_next  = (emit && (word_cnt != CNT_MAX)) ? word_cnt + CNT_W'(1) : word_cnt;

    hit_stream_tx_xft_fifo #(
        .DEPTH (XFT_DEPTH),
        .WIDTH (HIT_W)
    ) u_xft_fifo (
        .clock   (clock),
        .reset_n (reset_n),
        .push    (push),
        .pop     (pop),
        .wr_data (hit_data),
        .rd_data (fifo_rd_data),
        .full    (fifo_full),
        .empty   (fifo_empty),
        .count   (fifo_level)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state       <= S_IDLE;
            dout        <= '0;
            we          <= 1'b0;
            clear       <= 1'b0;
            evt_done    <= 1'b0;
            evt_words   <= '0;
            err_layer   <= 1'b0;
            err_xft_ovf <= 1'b0;
            word_cnt    <= '0;
        end else begin
            we          <= 1'b0;
            clear       <= 1'b0;
            evt_done    <= 1'b0;
            err_layer   <= 1'b0;
            err_xft_ovf <= 1'b0;
            word_cnt    <= cnt_next;

            unique case (state)
                S_IDLE: begin
                    if (hit_valid && !tx_hold) begin
                        state <= S_CLR;
                        clear <= 1'b1;
                    end
                end
                S_CLR: begin
                    word_cnt <= '0;
                    state    <= S_SVX;
                end
                S_SVX: begin
                    if (accept) begin
                        if (is_svx) begin
                            we   <= 1'b1;
                            dout <= svx_word(hit_layer, hit_data[SVX_PAYLOAD_W-1:0]);
                        end
                        if (is_xft && fifo_full) err_xft_ovf <= 1'b1;
                        if (bad_layer)           err_layer   <= 1'b1;
                        // A hit pushed together with eoe still belongs to this drain.
                        if (hit_eoe) begin
                            if (push || !fifo_empty) begin
                                state <= S_XHDR;
                            end else begin
                                state     <= S_DONE;
                                evt_done  <= 1'b1;
                                evt_words <= cnt_next;
                            end
                        end
                    end
                end
                S_XHDR: begin
                    if (!tx_hold) begin
                        we    <= 1'b1;
                        dout  <= XFT_MARKER;
                        state <= S_XDAT;
                    end
                end
                S_XDAT: begin
                    if (!tx_hold) begin
                        we   <= 1'b1;
                        dout <= xft_word(xft_hit_t'(fifo_rd_data));
                        if (fifo_level == FIFO_CW'(1)) begin
                            state     <= S_DONE;
                            evt_done  <= 1'b1;
                            evt_words <= cnt_next;
                        end else begin
                            state <= S_XHDR;
                        end
                    end
                end
                S_DONE: begin
                    state <= S_IDLE;
                end
                default: begin
                    state <= S_IDLE;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_hit_stream_tx.sv
// Self-checking bench for hit_stream_tx: directed scenarios plus randomized events
// scored against an event-level reference model of the expected word stream.
module tb_hit_stream_tx;

    localparam int unsigned DEPTH = 16;
    localparam logic [22:0] MARKER = 23'h140000;

    logic        clock = 1'b0;
    logic        reset_n = 1'b0;
    logic        hit_valid = 1'b0;
    logic        hit_ready;
    logic [2:0]  hit_layer = '0;
    logic [18:0] hit_data = '0;
    logic        hit_eoe = 1'b0;
    logic        tx_hold = 1'b0;
    logic [22:0] dout;
    logic        we;
    logic        clear;
    logic        evt_done;
    logic [9:0]  evt_words;
    logic        err_layer;
    logic        err_xft_ovf;

    int n_cmp = 0;
    int n_bad = 0;

    logic [22:0] obs_q[$];
    logic [22:0] exp_q[$];
    logic [2:0]  ev_layer[$];
    logic [18:0] ev_data[$];
    int          clr_seen, done_seen, errl_seen, ovf_seen, order_bad, ready_bad;
    logic [9:0]  obs_words;
    int          exp_err, exp_ovf, exp_words;

    hit_stream_tx #(.XFT_DEPTH(DEPTH)) dut (
        .clock       (clock),
        .reset_n     (reset_n),
        .hit_valid   (hit_valid),
        .hit_ready   (hit_ready),
        .hit_layer   (hit_layer),
        .hit_data    (hit_data),
        .hit_eoe     (hit_eoe),
        .tx_hold     (tx_hold),
        .dout        (dout),
        .we          (we),
        .clear       (clear),
        .evt_done    (evt_done),
        .evt_words   (evt_words),
        .err_layer   (err_layer),
        .err_xft_ovf (err_xft_ovf)
    );

    always #5 clock = ~clock;

    // Output monitor, sampled on the falling edge.
    always @(negedge clock) begin
        if (reset_n) begin
            if (we) begin
                obs_q.push_back(dout);
                if (clr_seen == 0) order_bad++;
            end
            if (clear) clr_seen++;
            if (evt_done) begin
                done_seen++;
                obs_words = evt_words;
            end
            if (err_layer)   errl_seen++;
            if (err_xft_ovf) ovf_seen++;
        end
    end

    initial begin
        #900000;
        $display("FAIL watchdog: simulation still running, want finished");
        $fatal(1);
    end

    task automatic clear_stats();
        obs_q.delete();
        clr_seen = 0; done_seen = 0; errl_seen = 0; ovf_seen = 0;
        order_bad = 0; ready_bad = 0; obs_words = '1;
    endtask

    task automatic new_event();
        ev_layer.delete();
        ev_data.delete();
    endtask

    task automatic add_hit(input logic [2:0] l, input logic [18:0] d);
        ev_layer.push_back(l);
        ev_data.push_back(d);
    endtask

    // Reference: SVX words in order, first DEPTH XFT hits as marker/data pairs.
    task automatic build_expected();
        logic [18:0] xq[$];
        exp_q.delete();
        exp_err = 0;
        exp_ovf = 0;
        for (int i = 0; i < ev_layer.size(); i++) begin
            if (ev_layer[i] <= 3'd4) begin
                exp_q.push_back({2'b00, ev_layer[i], ev_data[i][17:0]});
            end else if (ev_layer[i] == 3'd5) begin
                if (xq.size() < DEPTH) xq.push_back(ev_data[i]);
                else exp_ovf++;
            end else if (!(ev_layer[i] == 3'd7 && i == ev_layer.size() - 1)) begin
                exp_err++;
            end
        end
        foreach (xq[k]) begin
            exp_q.push_back(MARKER);
            exp_q.push_back({4'b0000, xq[k]});
        end
        exp_words = (exp_q.size() > 1023) ? 1023 : exp_q.size();
    endtask

    function automatic int diff_at();
        int n = (obs_q.size() < exp_q.size()) ? obs_q.size() : exp_q.size();
        for (int i = 0; i < n; i++) if (obs_q[i] !== exp_q[i]) return i;
        if (obs_q.size() != exp_q.size()) return n;
        return -1;
    endfunction

    function automatic logic [22:0] obs_at(input int i);
        return (i >= 0 && i < obs_q.size()) ? obs_q[i] : 23'hx;
    endfunction

    function automatic logic [22:0] exp_at(input int i);
        return (i >= 0 && i < exp_q.size()) ? exp_q[i] : 23'hx;
    endfunction

    task automatic send_items(input int hold_pct, output int to);
        int idx = 0;
        int cyc = 0;
        while (idx < ev_layer.size() && cyc < 1000) begin
            @(negedge clock);
            hit_valid = 1'b1;
            hit_layer = ev_layer[idx];
            hit_data  = ev_data[idx];
            hit_eoe   = (idx == ev_layer.size() - 1);
            tx_hold   = (int'($urandom_range(99)) < hold_pct);
            #1;
            if (hit_ready && tx_hold) ready_bad++;
            if (hit_ready) idx++;
            cyc++;
        end
        to = (idx < ev_layer.size()) ? 1 : 0;
    endtask

    task automatic drain(input int hold_pct, output int to);
        int cyc = 0;
        while (done_seen == 0 && cyc < 1000) begin
            @(negedge clock);
            hit_valid = 1'b0;
            hit_eoe   = 1'b0;
            tx_hold   = (int'($urandom_range(99)) < hold_pct);
            #1;
            if (hit_ready) ready_bad++;
            cyc++;
        end
        to = (done_seen == 0) ? 1 : 0;
        @(negedge clock);
        hit_valid = 1'b0;
        tx_hold   = 1'b0;
    endtask

    task automatic test_reset();
        reset_n = 1'b0;
        repeat (3) @(negedge clock);
        n_cmp++;
        if ({dout, we, clear, evt_done, evt_words, err_layer, err_xft_ovf, hit_ready} !== 39'd0) begin
            n_bad++;
            $display("FAIL reset_outputs: got %h, want 0",
                     {dout, we, clear, evt_done, evt_words, err_layer, err_xft_ovf, hit_ready});
        end
        reset_n = 1'b1;
        repeat (3) @(negedge clock);
        #1;
        n_cmp++;
        if ({we, clear, evt_done, hit_ready} !== 4'b0000) begin
            n_bad++;
            $display("FAIL idle_after_reset: got we/clr/done/rdy %b, want 0000",
                     {we, clear, evt_done, hit_ready});
        end
    endtask

    task automatic test_svx_basic();
        int to_s, to_d, d;
        clear_stats(); new_event();
        add_hit(3'd0, {2'b00, 3'd3, 1'b1, 14'h1234});
        add_hit(3'd4, 19'h00001);
        send_items(0, to_s); drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[0] !== 23'h01D234 || obs_q[1] !== 23'h100001) begin
            n_bad++;
            $display("FAIL svx_basic words: got %h %h (count %0d), want 01d234 100001",
                     obs_at(0), obs_at(1), obs_q.size());
        end
        n_cmp++;
        if (to_s || to_d || d >= 0) begin
            n_bad++;
            $display("FAIL svx_basic model: timeout %0d/%0d idx %0d got %h want %h",
                     to_s, to_d, d, obs_at(d), exp_at(d));
        end
        n_cmp++;
        if (obs_words !== 10'd2) begin
            n_bad++;
            $display("FAIL svx_basic evt_words: got %0d, want 2", obs_words);
        end
        n_cmp++;
        if (clr_seen !== 1 || done_seen !== 1 || order_bad !== 0 || ready_bad !== 0) begin
            n_bad++;
            $display("FAIL svx_basic protocol: clear %0d done %0d order %0d ready %0d, want 1 1 0 0",
                     clr_seen, done_seen, order_bad, ready_bad);
        end
    endtask

    task automatic test_mixed();
        int to_s, to_d, d;
        clear_stats(); new_event();
        add_hit(3'd1, 19'h01357);
        add_hit(3'd5, {1'b1, 6'd5, 12'h0AB});
        add_hit(3'd2, 19'h2468A);
        send_items(0, to_s); drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (obs_q.size() != 4 || obs_q[2] !== MARKER || obs_q[3] !== 23'h0450AB) begin
            n_bad++;
            $display("FAIL mixed xft_pair: got %h %h (count %0d), want 140000 0450ab",
                     obs_at(2), obs_at(3), obs_q.size());
        end
        n_cmp++;
        if (to_s || to_d || d >= 0) begin
            n_bad++;
            $display("FAIL mixed words: timeout %0d/%0d idx %0d got %h want %h",
                     to_s, to_d, d, obs_at(d), exp_at(d));
        end
        n_cmp++;
        if (obs_words !== 10'(exp_words) || clr_seen !== 1 || done_seen !== 1) begin
            n_bad++;
            $display("FAIL mixed event: words %0d clear %0d done %0d, want %0d 1 1",
                     obs_words, clr_seen, done_seen, exp_words);
        end
    endtask

    task automatic test_overflow();
        int to_s, to_d, d;
        clear_stats(); new_event();
        for (int i = 0; i < 17; i++) add_hit(3'd5, 19'($urandom));
        add_hit(3'd7, 19'd0);
        send_items(0, to_s); drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (ovf_seen !== 1 || errl_seen !== 0) begin
            n_bad++;
            $display("FAIL overflow errors: ovf %0d layer %0d, want 1 0", ovf_seen, errl_seen);
        end
        n_cmp++;
        if (obs_words !== 10'd32) begin
            n_bad++;
            $display("FAIL overflow evt_words: got %0d, want 32", obs_words);
        end
        n_cmp++;
        if (to_s || to_d || d >= 0) begin
            n_bad++;
            $display("FAIL overflow words: timeout %0d/%0d idx %0d got %h want %h",
                     to_s, to_d, d, obs_at(d), exp_at(d));
        end
    endtask

    task automatic test_hold();
        int to_s, to_d, d;
        int cyc = 0;
        clear_stats(); new_event();
        add_hit(3'd1, 19'h00777);
        add_hit(3'd5, 19'h2A5C3);
        add_hit(3'd5, 19'h15A3C);
        add_hit(3'd7, 19'd0);
        send_items(0, to_s);
        while (!(obs_q.size() > 0 && obs_q[obs_q.size() - 1] === MARKER) && cyc < 100) begin
            @(negedge clock);
            hit_valid = 1'b0; hit_eoe = 1'b0;
            #1;
            cyc++;
        end
        n_cmp++;
        if (cyc >= 100) begin
            n_bad++;
            $display("FAIL hold marker_wait: got no marker in %0d cycles, want marker", cyc);
        end
        tx_hold = 1'b1;
        for (int k = 0; k < 3; k++) begin
            @(negedge clock);
            #1;
            n_cmp++;
            if (we !== 1'b0 || hit_ready !== 1'b0) begin
                n_bad++;
                $display("FAIL hold stall_%0d: got we %b ready %b, want 0 0", k, we, hit_ready);
            end
        end
        tx_hold = 1'b0;
        @(negedge clock);
        #1;
        n_cmp++;
        if (we !== 1'b1 || dout !== 23'h02A5C3) begin
            n_bad++;
            $display("FAIL hold data_after: got we %b dout %h, want 1 02a5c3", we, dout);
        end
        drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (to_s || to_d || d >= 0 || ready_bad !== 0 || obs_words !== 10'(exp_words)) begin
            n_bad++;
            $display("FAIL hold event: timeout %0d/%0d idx %0d got %h want %h ready %0d words %0d/%0d",
                     to_s, to_d, d, obs_at(d), exp_at(d), ready_bad, obs_words, exp_words);
        end
    endtask

    task automatic test_bad_layer();
        int to_s, to_d, d;
        clear_stats(); new_event();
        add_hit(3'd0, 19'h00321);
        add_hit(3'd6, 19'h7FFFF);
        add_hit(3'd3, 19'h02222);
        send_items(0, to_s); drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (errl_seen !== 1 || ovf_seen !== 0) begin
            n_bad++;
            $display("FAIL bad_layer errors: layer %0d ovf %0d, want 1 0", errl_seen, ovf_seen);
        end
        n_cmp++;
        if (obs_q.size() != 2 || obs_q[1] !== 23'h0C2222) begin
            n_bad++;
            $display("FAIL bad_layer next_hit: got %h (count %0d), want 0c2222 (count 2)",
                     obs_at(1), obs_q.size());
        end
        n_cmp++;
        if (to_s || to_d || d >= 0 || obs_words !== 10'd2) begin
            n_bad++;
            $display("FAIL bad_layer event: timeout %0d/%0d idx %0d got %h want %h words %0d",
                     to_s, to_d, d, obs_at(d), exp_at(d), obs_words);
        end
    endtask

    task automatic test_reset_mid();
        int to_s, to_d, d;
        int cyc = 0;
        clear_stats(); new_event();
        for (int i = 0; i < 4; i++) add_hit(3'd5, 19'($urandom));
        add_hit(3'd7, 19'd0);
        send_items(0, to_s);
        while (!(obs_q.size() > 0 && obs_q[obs_q.size() - 1] === MARKER) && cyc < 100) begin
            @(negedge clock);
            hit_valid = 1'b0; hit_eoe = 1'b0;
            #1;
            cyc++;
        end
        #1 reset_n = 1'b0;
        #1;
        n_cmp++;
        if ({dout, we, clear, evt_done, evt_words, err_layer, err_xft_ovf, hit_ready} !== 39'd0
            || cyc >= 100) begin
            n_bad++;
            $display("FAIL reset_mid outputs: got %h (wait %0d), want 0",
                     {dout, we, clear, evt_done, evt_words, err_layer, err_xft_ovf, hit_ready}, cyc);
        end
        repeat (2) @(negedge clock);
        reset_n = 1'b1;
        clear_stats();
        repeat (4) @(negedge clock);
        #1;
        n_cmp++;
        if (done_seen !== 0 || obs_q.size() != 0) begin
            n_bad++;
            $display("FAIL reset_mid quiet: got done %0d words %0d, want 0 0", done_seen, obs_q.size());
        end
        new_event();
        add_hit(3'd2, 19'h0BEEF);
        send_items(0, to_s); drain(0, to_d);
        build_expected(); d = diff_at();
        n_cmp++;
        if (to_s || to_d || d >= 0 || clr_seen !== 1 || obs_words !== 10'd1) begin
            n_bad++;
            $display("FAIL reset_mid next_event: timeout %0d/%0d idx %0d got %h want %h clear %0d words %0d",
                     to_s, to_d, d, obs_at(d), exp_at(d), clr_seen, obs_words);
        end
    endtask

    task automatic test_random();
        int to_s, to_d, d, n, r;
        logic [2:0] l;
        for (int e = 0; e < 30; e++) begin
            clear_stats(); new_event();
            n = $urandom_range(1, 22);
            for (int i = 0; i < n; i++) begin
                r = $urandom_range(99);
                l = (r < 50) ? 3'($urandom_range(4)) : (r < 88) ? 3'd5 : (r < 94) ? 3'd6 : 3'd7;
                add_hit(l, 19'($urandom));
            end
            if (ev_layer[ev_layer.size() - 1] == 3'd6) ev_layer[ev_layer.size() - 1] = 3'd7;
            send_items(25, to_s); drain(25, to_d);
            build_expected(); d = diff_at();
            n_cmp++;
            if (to_s || to_d || d >= 0) begin
                n_bad++;
                $display("FAIL random_%0d words: timeout %0d/%0d idx %0d got %h want %h (count %0d want %0d)",
                         e, to_s, to_d, d, obs_at(d), exp_at(d), obs_q.size(), exp_q.size());
            end
            n_cmp++;
            if (obs_words !== 10'(exp_words) || errl_seen !== exp_err || ovf_seen !== exp_ovf) begin
                n_bad++;
                $display("FAIL random_%0d counts: words %0d err %0d ovf %0d, want %0d %0d %0d",
                         e, obs_words, errl_seen, ovf_seen, exp_words, exp_err, exp_ovf);
            end
            n_cmp++;
            if (clr_seen !== 1 || done_seen !== 1 || order_bad !== 0 || ready_bad !== 0) begin
                n_bad++;
                $display("FAIL random_%0d protocol: clear %0d done %0d order %0d ready %0d, want 1 1 0 0",
                         e, clr_seen, done_seen, order_bad, ready_bad);
            end
        end
    endtask

    initial begin
        clear_stats();
        test_reset();
        test_svx_basic();
        test_mixed();
        test_overflow();
        test_hold();
        test_bad_layer();
        test_reset_mid();
        test_random();
        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
